// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the ap_ctrl handshake performance monitor.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } mon_state_e;

  typedef enum logic [2:0] {
    FLD_INVOC       = 3'd0,
    FLD_LAT_LAST    = 3'd1,
    FLD_LAT_MIN     = 3'd2,
    FLD_LAT_MAX     = 3'd3,
    FLD_BUSY_TOTAL  = 3'd4,
    FLD_STALL_TOTAL = 3'd5,
    FLD_STATUS      = 3'd6,
    FLD_RSVD        = 3'd7
  } mon_field_e;

  // STATUS word layout: {.., ovf, finish_seen, state[1:0]}
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_FIN_BIT   = 2;
  localparam int STAT_OVF_BIT   = 3;

endpackage

// File: rtl/ap_ctrl_chan_counter.sv
// One monitored handshake channel: tracking FSM plus saturating counters.
module ap_ctrl_chan_counter
  import perf_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  output logic [CNT_W-1:0] invoc,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] busy_total,
  output logic [CNT_W-1:0] stall_total,
  output logic [1:0]       state,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  mon_state_e       st, st_nxt;
  logic [CNT_W-1:0] lat, lat_cur;
  logic             starting, completing, stalling, working, lat_upd, lat_sat, ovf_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ONES) ? v : v + ONE;
  endfunction

  assign state = st;

  // Next state and per-cycle events; lat_cur is the latency including this cycle
  always_comb begin
    st_nxt     = st;
    starting   = 1'b0;
    completing = 1'b0;
    stalling   = 1'b0;
    working    = 1'b0;
    lat_cur    = lat;
    case (st)
      IDLE: begin
        if (ap_start) begin
          starting = 1'b1;
          working  = 1'b1;
          lat_cur  = ONE;
          if (ap_done) begin
            completing = 1'b1;
            stalling   = !ap_continue;
            st_nxt     = ap_continue ? IDLE : HOLD;
          end else begin
            st_nxt = RUN;
          end
        end
      end
      RUN: begin
        working = 1'b1;
        lat_cur = sat_inc(lat);
        if (ap_done) begin
          completing = 1'b1;
          stalling   = !ap_continue;
          st_nxt     = ap_continue ? IDLE : HOLD;
        end
      end
      HOLD: begin
        working = 1'b1;
        if (ap_continue) st_nxt = IDLE;
        else             stalling = 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
    lat_upd = starting || (st == RUN);
    lat_sat = (lat_cur == ONES);
    ovf_hit = (starting && (sat_inc(invoc) == ONES)) ||
              (lat_upd  && lat_sat) ||
              (working  && (sat_inc(busy_total) == ONES)) ||
              (stalling && (sat_inc(stall_total) == ONES));
  end

  // State register and gated counter updates; clear behaves like reset
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      st          <= IDLE;
      lat         <= '0;
      invoc       <= '0;
      lat_last    <= '0;
      lat_min     <= ONES;
      lat_max     <= '0;
      busy_total  <= '0;
      stall_total <= '0;
      ovf         <= 1'b0;
    end else begin
      st <= st_nxt;
      if (cnt_en) begin
        if (starting) invoc <= sat_inc(invoc);
        if (lat_upd)  lat <= lat_cur;
        if (completing) begin
          lat_last <= lat_cur;
          if (!lat_sat) begin
            if (lat_cur < lat_min) lat_min <= lat_cur;
            if (lat_cur > lat_max) lat_max <= lat_cur;
          end
        end
        if (working)  busy_total  <= sat_inc(busy_total);
        if (stalling) stall_total <= sat_inc(stall_total);
        if (ovf_hit)  ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// N-channel ap_ctrl_hs/ap_ctrl_chain performance monitor with registered readout.
module ap_ctrl_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                finish,
  input  logic [NUM_CH-1:0]   ap_start,
  input  logic [NUM_CH-1:0]   ap_done,
  input  logic [NUM_CH-1:0]   ap_continue,
  input  logic [CH_IDX_W-1:0] rd_ch,
  input  logic [2:0]          rd_field,
  output logic [CNT_W-1:0]    rd_data,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   ovf
);

  logic             finish_seen, cnt_en;
  logic [CNT_W-1:0] invoc_a  [NUM_CH];
  logic [CNT_W-1:0] last_a   [NUM_CH];
  logic [CNT_W-1:0] min_a    [NUM_CH];
  logic [CNT_W-1:0] max_a    [NUM_CH];
  logic [CNT_W-1:0] busyt_a  [NUM_CH];
  logic [CNT_W-1:0] stallt_a [NUM_CH];
  logic [1:0]       state_a  [NUM_CH];
  logic [CNT_W-1:0] fld;

  // End-of-run latch: once finish is seen, counters stay frozen until clear/reset
  always_ff @(posedge clock) begin
    if (!reset || clear) finish_seen <= 1'b0;
    else if (finish)     finish_seen <= 1'b1;
  end

  assign cnt_en = enable && !finish && !finish_seen;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_ctrl_chan_counter #(.CNT_W(CNT_W)) u_chan (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .cnt_en      (cnt_en),
      .ap_start    (ap_start[g]),
      .ap_done     (ap_done[g]),
      .ap_continue (ap_continue[g]),
      .invoc       (invoc_a[g]),
      .lat_last    (last_a[g]),
      .lat_min     (min_a[g]),
      .lat_max     (max_a[g]),
      .busy_total  (busyt_a[g]),
      .stall_total (stallt_a[g]),
      .state       (state_a[g]),
      .ovf         (ovf[g])
    );
    assign busy[g] = (state_a[g] != IDLE);
  end

  // Field select; unknown channels and the reserved code read as zero
  always_comb begin
    fld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_IDX_W'(i)) begin
        case (mon_field_e'(rd_field))
          FLD_INVOC:       fld = invoc_a[i];
          FLD_LAT_LAST:    fld = last_a[i];
          FLD_LAT_MIN:     fld = min_a[i];
          FLD_LAT_MAX:     fld = max_a[i];
          FLD_BUSY_TOTAL:  fld = busyt_a[i];
          FLD_STALL_TOTAL: fld = stallt_a[i];
          FLD_STATUS: begin
            fld[STAT_OVF_BIT]         = ovf[i];
            fld[STAT_FIN_BIT]         = finish_seen;
            fld[STAT_STATE_LSB +: 2]  = state_a[i];
          end
          default:         fld = '0;
        endcase
      end
    end
  end

  // Registered readout, one cycle behind the index/field presentation
  always_ff @(posedge clock) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= fld;
  end

endmodule
